// File: rtl/phy_tx_frame_buffer.sv
`timescale 1ns/1ps
// Store-and-forward AXI-Stream frame buffer feeding the PHY TX path.
// Frames are written into a circular RAM and only become visible to the
// read side once their last beat is committed. Oversize frames, frames that
// run out of space and frames that would overflow the frame counter are
// dropped and reported on o_drop.
//
// Handshake: a beat moves on a channel in any cycle where valid and ready
// are both high; while valid is high and ready is low the source holds its
// beat (data/keep/last) stable and keeps valid asserted.
module phy_tx_frame_buffer #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [63:0]      s_axis_data,
    input  logic [7:0]       s_axis_keep,
    input  logic             s_axis_last,
    input  logic             s_axis_valid,
    output logic             s_axis_ready,
    output logic [63:0]      m_axis_data,
    output logic [7:0]       m_axis_keep,
    output logic             m_axis_last,
    output logic             m_axis_valid,
    input  logic             m_axis_ready,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_drop
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam int                PTR_W   = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  MAX_P   = PTR_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND}   r_state_e;

    // RAM word layout: {last, keep[7:0], data[63:0]}
    logic [72:0] mem [DEPTH];
    logic [72:0] rdata_q;

    w_state_e         w_state_q, w_state_d;
    r_state_e         r_state_q, r_state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             s_ready_q;
    logic             drop_q, drop_d;

    logic accept, full, too_long, cnt_sat;
    logic wr_en, commit, rd_en, rd_done;

    assign accept   = s_axis_valid & s_ready_q;
    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign too_long = (wr_ptr_q - wr_commit_q) >= MAX_P;
    // The output register is the RAM read register, so its last bit tells
    // whether the beat on the bus closes the frame.
    assign rd_done  = (r_state_q == R_SEND) & m_axis_ready & rdata_q[72];
    // A commit is refused only when no frame leaves in the same cycle.
    assign cnt_sat  = (frame_cnt_q == CNT_MAX) & ~rd_done;

    // Write side: accept, drop or commit the incoming beat.
    always_comb begin
        w_state_d   = w_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        wr_en       = 1'b0;
        commit      = 1'b0;
        drop_d      = 1'b0;
        case (w_state_q)
            W_IDLE, W_RECV: begin
                if (accept) begin
                    if (full | too_long | (s_axis_last & cnt_sat)) begin
                        // Rewind to the last committed frame boundary.
                        wr_ptr_d = wr_commit_q;
                        if (s_axis_last) begin
                            drop_d    = 1'b1;
                            w_state_d = W_IDLE;
                        end else begin
                            w_state_d = W_DISCARD;
                        end
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (s_axis_last) begin
                            commit      = 1'b1;
                            wr_commit_d = wr_ptr_q + 1'b1;
                            w_state_d   = W_IDLE;
                        end else begin
                            w_state_d = W_RECV;
                        end
                    end
                end
            end
            W_DISCARD: begin
                if (accept & s_axis_last) begin
                    drop_d    = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Committed-frame counter: commit and read-complete cancel out.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        case ({commit, rd_done})
            2'b10:   frame_cnt_d = frame_cnt_q + 1'b1;
            2'b01:   frame_cnt_d = frame_cnt_q - 1'b1;
            default: frame_cnt_d = frame_cnt_q;
        endcase
    end

    // Read side: fetch the first word, then read one word per accepted beat.
    always_comb begin
        r_state_d = r_state_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (frame_cnt_q != '0) begin
                    rd_en     = 1'b1;
                    r_state_d = R_SEND;
                end
            end
            R_FETCH: begin
                if (frame_cnt_q != '0) begin
                    rd_en     = 1'b1;
                    r_state_d = R_SEND;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_SEND: begin
                if (m_axis_ready) begin
                    if (rdata_q[72]) begin
                        // rd_ptr already sits on the next frame's first word.
                        r_state_d = (frame_cnt_d != '0) ? R_FETCH : R_IDLE;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        rd_ptr_d = rd_en ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    end

    // State, pointer and flag registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            s_ready_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            s_ready_q   <= 1'b1;
            drop_q      <= drop_d;
        end
    end

    // RAM write port.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_last, s_axis_keep, s_axis_data};
        end
    end

    // Registered RAM read port, doubling as the output beat register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    assign s_axis_ready = s_ready_q;
    assign m_axis_data  = rdata_q[63:0];
    assign m_axis_keep  = rdata_q[71:64];
    assign m_axis_last  = rdata_q[72];
    assign m_axis_valid = (r_state_q == R_SEND);
    assign o_frame_cnt  = frame_cnt_q;
    assign o_drop       = drop_q;

endmodule

// File: doc/phy_tx_frame_buffer.md
Name: phy_tx_frame_buffer

Overview:
- Store-and-forward AXI-Stream frame buffer in the TX clock domain, directly upstream of the PHY TX path (drives its s_axis_* port).
- Accepts user frames at arbitrary valid gaps. Forwards only complete frames, as back-to-back beats with no valid bubbles inside a frame, so the 64B/66B encoder never sees a mid-frame underrun.
- Drops frames that overflow the buffer or exceed the maximum length, and reports each drop.

Parameters:
- ADDR_W, 9, log2 of data RAM depth in 64-bit words (DEPTH = 2^ADDR_W = 512).
- MAX_WORDS, 256, maximum frame length in beats; longer frames are dropped. Must be ≤ DEPTH.
- CNT_W, 8, width of the committed-frame counter.

Ports:
- i_clk  in  1  TX user clock.
- i_rst  in  1  synchronous active-high reset.
- s_axis_data  in  64  user frame data.
- s_axis_keep  in  8  byte enables; meaningful on the last beat only.
- s_axis_last  in  1  last beat of frame.
- s_axis_valid  in  1  beat valid.
- s_axis_ready  out  1  buffer ready.
- m_axis_data  out  64  data to PHY TX.
- m_axis_keep  out  8  byte enables to PHY TX.
- m_axis_last  out  1  last beat to PHY TX.
- m_axis_valid  out  1  beat valid to PHY TX.
- m_axis_ready  in  1  PHY TX ready.
- o_frame_cnt  out  CNT_W  number of committed, unsent frames.
- o_drop  out  1  one-cycle pulse per dropped frame.

Behaviour:
- Interface decision (as decided): one clock; reset is synchronous and active-high; clock port i_clk, reset port i_rst.
- Reset values: s_axis_ready=0, m_axis_valid=0, m_axis_data/keep/last=0, o_frame_cnt=0, o_drop=0. All pointers are cleared. s_axis_ready rises on the first cycle after i_rst deasserts.
- Storage: one RAM of DEPTH x 73 bits {last, keep, data}, with a registered read port (1-cycle latency).
- Pointers are ADDR_W+1 bits wide: wr_ptr, wr_commit, rd_ptr. Full when wr_ptr - rd_ptr == DEPTH, using modular arithmetic; wrap-around via the MSB is required.
- Write side, state machine W_IDLE/W_RECV/W_DISCARD:
  - An accepted beat (valid & ready) writes to wr_ptr, and wr_ptr increments.
  - W_IDLE→W_RECV on the first accepted beat without last. A single-beat frame commits immediately and stays in W_IDLE.
  - Commit on an accepted last beat: wr_commit ← wr_ptr+1, and the frame counter increments.
  - Overflow: a beat arrives while full, or the beat count would exceed MAX_WORDS. Then wr_ptr ← wr_commit, no write occurs, and the state goes to W_DISCARD. If that beat carried last, o_drop pulses next cycle and the state returns to W_IDLE.
  - W_DISCARD: s_axis_ready=1; all beats are discarded. On an accepted last beat: o_drop pulses for 1 cycle, then W_IDLE.
  - s_axis_ready=1 at all times after reset. Overflow is handled by drop, not by backpressure.
- Read side, state machine R_IDLE/R_FETCH/R_SEND:
  - R_IDLE→R_FETCH when frame_cnt>0: issue a RAM read at rd_ptr.
  - R_FETCH→R_SEND: the output register loads and m_axis_valid=1.
  - R_SEND: the next word is prefetched so that m_axis_valid stays 1 on every cycle until the last beat. Data holds stable while m_axis_ready=0.
  - On an accepted last beat: frame counter decrements, rd_ptr now points at the next frame.
    - If frame_cnt (after update) > 0: go directly to R_FETCH (one idle cycle between frames allowed).
    - Otherwise: go to R_IDLE with m_axis_valid=0.
- Latency: last beat accepted on the input at cycle N → first beat m_axis_valid at cycle N+2 at the earliest (buffer initially empty).
- Simultaneous commit and read-complete in one cycle: o_frame_cnt is unchanged.
- Counter saturation: o_frame_cnt never exceeds 2^CNT_W-1. If a commit would overflow it, the frame is treated as an overflow drop.
- The read side must never pass wr_commit. Uncommitted words are never output.
- Keep values are stored and forwarded unmodified. Keep on non-last beats is passed through as received.

Test Plan:
- Single 1-beat frame (data=64'h0123456789ABCDEF, keep=8'h0F, last=1) at cycle 10 → m_axis beat with identical data/keep/last at cycle 12; o_frame_cnt=1 at cycle 11, 0 after the beat is accepted.
- 8-beat frame with s_axis_valid toggling 1/0 each cycle → output emits 8 contiguous valid beats with no gaps while m_axis_ready=1; m_axis_last only on beat 8.
- Backpressure: m_axis_ready low for 5 cycles mid-frame → m_axis_data/keep/last held constant; no beat lost or duplicated.
- Overflow: ADDR_W=4 (16 words), send a 10-beat frame, hold m_axis_ready=0, send a second 10-beat frame → first frame delivered intact, second dropped, o_drop pulses once, o_frame_cnt=1.
- Oversize: MAX_WORDS=4, send a 6-beat frame followed by a 3-beat frame → o_drop pulses once; only the 3-beat frame is output.
- Reset mid-operation: assert i_rst during an output frame → next cycle m_axis_valid=0, o_frame_cnt=0, s_axis_ready=0; after release, a new 2-beat frame passes through correctly.
